// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end with prefetch FIFO.
// Owns the fetch PC and keeps at most one request outstanding to a
// variable-latency instruction memory. Returned words are tagged with their
// PC and buffered in a small FIFO whose head feeds decode through a
// valid/ready handshake. A redirect flushes the FIFO and discards any
// in-flight response.
// Optional build macro: FETCH_STATS_EN adds saturating FetchCount,
// StallCycles and FlushCount outputs.
module fetch_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        InstrReady,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] PCNow,
  output logic [31:0] PCNext4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } stateT;

  stateT             state, stateNext;
  logic [31:0]       fetchPc;
  logic [31:0]       reqPc;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [31:0]       instrMem [DEPTH];
  logic [31:0]       pcMem    [DEPTH];
  logic              issue;
  logic              push;
  logic              pop;

  // State register; reset forgets any outstanding request.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state, request issue and push decision; redirect overrides all.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!Redirect && (count < FULL_COUNT)) begin
          issue     = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (Redirect)       stateNext = ImemValid ? IDLE : DRAIN;
        else if (ImemValid) begin
          push      = 1'b1;
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        if (ImemValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign pop      = (count != '0) && InstrReady && !Redirect;
  assign ImemReq  = issue && !Reset;
  assign ImemAddr = fetchPc;

  // Fetch PC, FIFO storage, pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetchPc <= RESET_PC & 32'hFFFF_FFFC;
      reqPc   <= RESET_PC & 32'hFFFF_FFFC;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
    end else if (Redirect) begin
      fetchPc <= RedirectPC & 32'hFFFF_FFFC;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
    end else begin
      if (issue) begin
        fetchPc <= fetchPc + 32'd4;
        reqPc   <= fetchPc;
      end
      if (push) begin
        instrMem[wrPtr] <= ImemData;
        pcMem[wrPtr]    <= reqPc;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign InstrValid  = (count != '0);
  assign Instruction = InstrValid ? instrMem[rdPtr] : '0;
  assign PCNow       = InstrValid ? pcMem[rdPtr] : '0;
  assign PCNext4     = InstrValid ? (pcMem[rdPtr] + 32'd4) : '0;

`ifdef FETCH_STATS_EN
  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FetchCount  <= '0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (push && (FetchCount != '1))                          FetchCount  <= FetchCount + 32'd1;
      if (InstrValid && !InstrReady && (StallCycles != '1))    StallCycles <= StallCycles + 32'd1;
      if (Redirect && (FlushCount != '1))                      FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a per-cycle table of inputs and
// hand-computed expected outputs, followed by a hand-written redirect
// sequence with bounded waits.
module tb_fetch_prefetch_queue;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrReady;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] PCNow;
  logic [31:0] PCNext4;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

  fetch_prefetch_queue #(
    .RESET_PC(32'h0000_0040),
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ImemReq(ImemReq),
    .ImemAddr(ImemAddr),
    .ImemValid(ImemValid),
    .ImemData(ImemData),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC),
    .InstrReady(InstrReady),
    .InstrValid(InstrValid),
    .Instruction(Instruction),
    .PCNow(PCNow),
    .PCNext4(PCNext4)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount(FetchCount),
    .StallCycles(StallCycles),
    .FlushCount(FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rdPc;
    logic        rdy;
    logic        v;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] n4;
  } vecT;

  vecT vecs[$];
  int  total = 0;
  int  bad   = 0;

  task automatic addRow(input logic rst, input logic rd, input logic [31:0] rdPc,
                        input logic rdy, input logic v, input logic [31:0] data,
                        input logic req, input logic [31:0] addr, input logic iv,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] n4);
    vecT r;
    r.rst = rst; r.rd = rd; r.rdPc = rdPc; r.rdy = rdy; r.v = v; r.data = data;
    r.req = req; r.addr = addr; r.iv = iv; r.instr = instr; r.pc = pc; r.n4 = n4;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  initial begin
    bit found;

    //     rst rd rdPc          rdy v  data           req addr          iv instr          pc            n4
    // reset PC 0x40, 1-cycle memory
    addRow(1, 0, 32'h0,         1, 0, 32'h0,          0, 32'h40,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h40,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'h2001_0005,  0, 32'h44,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h44,        1, 32'h2001_0005, 32'h40,       32'h44);
    addRow(0, 0, 32'h0,         1, 1, 32'h2002_0003,  0, 32'h48,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h48,        1, 32'h2002_0003, 32'h44,       32'h48);
    // redirect to 0 from WAIT, discard response for 0x48
    addRow(0, 1, 32'h0,         1, 0, 32'h0,          0, 32'h4C,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    // decode stalled: fill to DEPTH then stop requesting
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         0, 1, 32'hA000_0000,  0, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h4,         1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 1, 32'hA000_0001,  0, 32'h8,         1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h8,         1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 1, 32'hA000_0002,  0, 32'hC,         1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'hC,         1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 1, 32'hA000_0003,  0, 32'h10,        1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h10,        1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h10,        1, 32'hA000_0000, 32'h0,        32'h4);
    // release stall: pops in order, fetch resumes at 0x10
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h10,        1, 32'hA000_0000, 32'h0,        32'h4);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h10,        1, 32'hA000_0001, 32'h4,        32'h8);
    addRow(0, 0, 32'h0,         1, 1, 32'hA000_0004,  0, 32'h14,        1, 32'hA000_0002, 32'h8,        32'hC);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h14,        1, 32'hA000_0003, 32'hC,        32'h10);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h18,        1, 32'hA000_0004, 32'h10,       32'h14);
    // redirect to 0x103 in WAIT with non-empty FIFO, 3-cycle memory
    addRow(0, 1, 32'h0000_0103, 0, 0, 32'h0,          0, 32'h18,        1, 32'hA000_0004, 32'h10,       32'h14);
    addRow(0, 0, 32'h0,         1, 1, 32'hDEAD_0014,  0, 32'h100,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hB000_0000,  0, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h104,       1, 32'hB000_0000, 32'h100,      32'h104);
    // redirect coincident with ImemValid and InstrReady
    addRow(0, 1, 32'h0000_0200, 1, 1, 32'hC000_0000,  0, 32'h108,       1, 32'hB000_0000, 32'h100,      32'h104);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h200,       0, 32'h0,         32'h0,        32'h0);
    // redirect to top of address space, PC wraps
    addRow(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,          0, 32'h204,       0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hDEAD_0204,  0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hD000_0000,  0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         1, 32'hD000_0000, 32'hFFFF_FFFC, 32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hD000_0001,  0, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,         1, 32'hD000_0001, 32'h0,        32'h4);
    // reset mid-WAIT with responses during and right after reset
    addRow(1, 0, 32'h0,         1, 1, 32'hE000_0000,  0, 32'h8,         0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hE000_0001,  1, 32'h40,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h44,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 1, 32'hE000_0002,  0, 32'h44,        0, 32'h0,         32'h0,        32'h0);
    addRow(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h44,        1, 32'hE000_0002, 32'h40,       32'h44);

    Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b1;
    ImemValid = 1'b0; ImemData = '0;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      Reset      = vecs[i].rst;
      Redirect   = vecs[i].rd;
      RedirectPC = vecs[i].rdPc;
      InstrReady = vecs[i].rdy;
      ImemValid  = vecs[i].v;
      ImemData   = vecs[i].data;
      @(negedge Clk);
      check("ImemReq",     i, {31'b0, ImemReq},    {31'b0, vecs[i].req});
      check("ImemAddr",    i, ImemAddr,            vecs[i].addr);
      check("InstrValid",  i, {31'b0, InstrValid}, {31'b0, vecs[i].iv});
      check("Instruction", i, Instruction,         vecs[i].instr);
      check("PCNow",       i, PCNow,               vecs[i].pc);
      check("PCNext4",     i, PCNext4,             vecs[i].n4);
      @(posedge Clk);
    end

    // Hand sequence: misaligned redirect from WAIT, late discarded response.
    #1;
    Reset = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0307;
    ImemValid = 1'b0; InstrReady = 1'b1;
    @(posedge Clk); #1;
    Redirect = 1'b0;
    @(posedge Clk); #1;
    ImemValid = 1'b1; ImemData = 32'hDEAD_0048;
    @(posedge Clk); #1;
    ImemValid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge Clk);
      if (ImemReq) found = 1'b1;
    end
    check("seqReqSeen", 100, {31'b0, found}, 32'd1);
    check("seqReqAddr", 100, ImemAddr, 32'h0000_0304);
    @(posedge Clk); #1;
    ImemValid = 1'b1; ImemData = 32'hF000_0000;
    @(posedge Clk); #1;
    ImemValid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge Clk);
      if (InstrValid) found = 1'b1;
    end
    check("seqHeadSeen",  101, {31'b0, found}, 32'd1);
    check("seqHeadInstr", 101, Instruction, 32'hF000_0000);
    check("seqHeadPC",    101, PCNow, 32'h0000_0304);
    check("seqHeadPC4",   101, PCNext4, 32'h0000_0308);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory, which has variable latency.
- Buffers returned instructions, each tagged with its PC and PC+4, in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; decode stall drives ready low.
- Handles branch/jump redirects by flushing the FIFO and discarding the in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ImemReq  out  1  one-cycle request strobe to instruction memory.
- ImemAddr  out  32  request address; always word aligned.
- ImemValid  in  1  response strobe.
- ImemData  in  32  response instruction word.
- Redirect  in  1  branch/jump taken this cycle.
- RedirectPC  in  32  new fetch target.
- InstrReady  in  1  decode accepts; driven as ~Stall.
- InstrValid  out  1  FIFO head valid.
- Instruction  out  32  head instruction; 32'b0 (NOP bubble) when not valid.
- PCNow  out  32  PC of the head instruction.
- PCNext4  out  32  PCNow+4, modulo 2^32.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - fetch PC = RESET_PC; FIFO count and pointers = 0; state = IDLE.
  - ImemReq = 0; ImemAddr = RESET_PC; InstrValid = 0; Instruction = 0; PCNow = 0; PCNext4 = 0.
  - Reset asserted mid-fetch drops the outstanding response; any ImemValid in the reset cycle or after it, until a new request is issued, is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DRAIN: a request outstanding whose response must be discarded.
- IDLE:
  - If count < DEPTH and Redirect = 0: assert ImemReq for one cycle with ImemAddr = fetch PC, set fetch PC += 4 (wraps at 2^32), go to WAIT.
  - Credit rule: a request issues only when count + 1 <= DEPTH, so a response never finds the FIFO full.
- WAIT:
  - On ImemValid with Redirect = 0: push {ImemData, issued PC, issued PC+4}, go to IDLE.
  - The next request may issue in the cycle after the push. Maximum throughput is therefore one instruction per 2 cycles with 1-cycle memory.
- Redirect (handled in any state, top priority after Reset):
  - fetch PC = {RedirectPC[31:2], 2'b00}; FIFO cleared; no ImemReq that cycle.
  - WAIT, or DRAIN without ImemValid, goes to DRAIN; IDLE stays IDLE.
  - DRAIN or WAIT with ImemValid in the same cycle as Redirect: the response is discarded and the state goes to IDLE.
- DRAIN: on ImemValid, discard the data and go to IDLE.
- Output side:
  - InstrValid = (count != 0); the head fields are registered FIFO contents.
  - Pop when InstrValid & InstrReady & ~Redirect.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on an empty FIFO is a no-op.
- Latency:
  - ImemValid at cycle t gives InstrValid at t+1.
  - Redirect at t gives ImemReq at t+1 if the block was IDLE; otherwise ImemReq one cycle after the discarded response.
- InstrReady low holds all head outputs stable; the FIFO keeps filling until count = DEPTH, then requests stop.
- The FIFO pointers wrap modulo DEPTH.

Optional Feature:
- FETCH_STATS_EN. When defined, adds three 32-bit outputs, each cleared by Reset and each saturating at 32'hFFFF_FFFF:
  - FetchCount: increments per accepted (pushed) response.
  - StallCycles: increments each cycle with InstrValid & ~InstrReady.
  - FlushCount: increments per Redirect.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, then memory returning 1-cycle responses 32'h2001_0005, 32'h2002_0003 -> ImemAddr 0x40 then 0x44; head PCNow=0x40, PCNext4=0x44, Instruction=32'h2001_0005 one cycle after the response.
- Hold InstrReady=0 with 1-cycle memory -> exactly 4 requests issued (0x00..0x0C), then ImemReq stays 0 and the head stays 0x00 stable. Raise InstrReady -> entries pop in order 0x00, 0x04, 0x08, 0x0C and fetching resumes at 0x10.
- Redirect to 32'h0000_0103 while WAIT with a 3-cycle memory -> FIFO empty next cycle and the old response discarded. The next ImemAddr is 0x100 and the next valid head has PCNow=0x100.
- Redirect coincident with ImemValid and InstrReady -> no push, no pop, count=0, state IDLE; next ImemReq to the redirect target the following cycle.
- Redirect to 32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; the first head has PCNext4=0x0000_0000.
- Reset asserted mid-WAIT, with ImemValid arriving during and after the reset cycle -> response ignored, InstrValid=0, and the first post-reset ImemAddr = RESET_PC.
